// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//   Multiply/divide sequencer for the HI/LO path. Accepts MULT, MULTU, DIV,
//   DIVU, MTHI and MTLO from EX. It runs a one-cycle registered multiply or a
//   32-iteration restoring divide, stalls EX while busy, and then drives the
//   HI/LO register write port for one cycle.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   op_valid   in   first-cycle-in-EX pulse for the current instruction
//   op_code    in   1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO (0/7 ignored)
//   src_a      in   rs operand (dividend / multiplicand / MTHI-MTLO data)
//   src_b      in   rt operand (divisor / multiplier)
//   flush      in   kills the op in flight and suppresses any write this cycle
//   busy       out  stall request to EX
//   hilo_mode  out  00 none, 01 LO only, 10 HI only, 11 both
//   hilo_hi    out  HI write data
//   hilo_lo    out  LO write data
// -----------------------------------------------------------------------------
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic [1:0]  hilo_mode,
  output logic [31:0] hilo_hi,
  output logic [31:0] hilo_lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t      state_q, state_d;
  logic [2:0]  opCode_q, opCode_d;
  logic [31:0] opA_q, opA_d;
  logic [31:0] opB_q, opB_d;
  logic        signA_q, signA_d;
  logic        signB_q, signB_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] work_q, work_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic        isLongOp;
  logic [31:0] absA, absB;
  logic [63:0] extA, extB, product;
  logic [32:0] remShift;
  logic        divGeq;
  logic [31:0] remNext;
  logic [63:0] workIter;
  logic [31:0] quotFix, remFix;

  // An op is taken only from IDLE or WB (the WB cycle frees EX), and never
  // while a flush is pending. MUL/DIV ignore op_valid since busy holds EX.
  always_comb begin
    accept   = op_valid && (op_code != 3'd0) && (op_code != 3'd7) && !flush &&
               ((state_q == IDLE) || (state_q == WB));
    isLongOp = (op_code == OP_MULT) || (op_code == OP_MULTU) ||
               (op_code == OP_DIV)  || (op_code == OP_DIVU);
  end

  // Stall covers the accept cycle of a long op and every MUL/DIV cycle; WB
  // leaves it low so the owning instruction moves on while its result writes.
  always_comb begin
    busy = (accept && isLongOp) || (state_q == MUL) || (state_q == DIV);
  end

  // A squashed or reset cycle must never write HI/LO, even from WB.
  always_comb begin
    hilo_mode = 2'b00;
    if ((state_q == WB) && !flush && !reset) begin
      case (opCode_q)
        OP_MTHI: hilo_mode = 2'b10;
        OP_MTLO: hilo_mode = 2'b01;
        default: hilo_mode = 2'b11;
      endcase
    end
    hilo_hi = hi_q;
    hilo_lo = lo_q;
  end

  // Arithmetic helpers. The product is taken modulo 2^64 on extended operands,
  // which yields the correct signed or unsigned 64-bit result.
  // The restoring step compares the 33-bit shifted remainder against the
  // divisor; when it fits, the difference is below 2^32 so the low 32 bits of
  // the subtraction are exact. A zero divisor always "fits", giving all-ones
  // quotient and the dividend back as remainder.
  always_comb begin
    absA     = src_a[31] ? (32'd0 - src_a) : src_a;
    absB     = src_b[31] ? (32'd0 - src_b) : src_b;
    extA     = (opCode_q == OP_MULT) ? {{32{opA_q[31]}}, opA_q} : {32'd0, opA_q};
    extB     = (opCode_q == OP_MULT) ? {{32{opB_q[31]}}, opB_q} : {32'd0, opB_q};
    product  = extA * extB;
    remShift = work_q[63:31];
    divGeq   = remShift >= {1'b0, opB_q};
    remNext  = divGeq ? (remShift[31:0] - opB_q) : remShift[31:0];
    workIter = {remNext, work_q[30:0], divGeq};
    quotFix  = workIter[31:0];
    remFix   = workIter[63:32];
    if (opCode_q == OP_DIV) begin
      if (signA_q ^ signB_q) begin
        quotFix = 32'd0 - workIter[31:0];
      end
      if (signA_q) begin
        remFix = 32'd0 - workIter[63:32];
      end
    end
  end

  // Next-state logic. Flush wins over everything and clears the divider.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, WB: begin
          state_d = IDLE;
          if (accept) begin
            case (op_code)
              OP_MULT, OP_MULTU: state_d = MUL;
              OP_DIV, OP_DIVU:   state_d = DIV;
              default:           state_d = WB;
            endcase
          end
        end
        MUL: state_d = WB;
        DIV: begin
          if (cnt_q == 5'd31) begin
            state_d = WB;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next-state. Results are loaded into the HI/LO data registers on
  // the edge entering WB, so they are stable for the whole WB cycle and then
  // hold afterwards. MTHI/MTLO load their data at the accept edge.
  always_comb begin
    opCode_d = opCode_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    signA_d  = signA_q;
    signB_d  = signB_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (flush) begin
      cnt_d  = 5'd0;
      work_d = 64'd0;
    end else if (accept) begin
      opCode_d = op_code;
      opA_d    = src_a;
      opB_d    = src_b;
      signA_d  = 1'b0;
      signB_d  = 1'b0;
      cnt_d    = 5'd0;
      work_d   = 64'd0;
      case (op_code)
        OP_DIV: begin
          signA_d = src_a[31];
          signB_d = src_b[31];
          opB_d   = absB;
          work_d  = {32'd0, absA};
        end
        OP_DIVU: work_d = {32'd0, src_a};
        OP_MTHI: hi_d = src_a;
        OP_MTLO: lo_d = src_a;
        default: ;
      endcase
    end else begin
      case (state_q)
        MUL: begin
          hi_d = product[63:32];
          lo_d = product[31:0];
        end
        DIV: begin
          work_d = workIter;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            hi_d = remFix;
            lo_d = quotFix;
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      opCode_q <= 3'd0;
      opA_q    <= 32'd0;
      opB_q    <= 32'd0;
      signA_q  <= 1'b0;
      signB_q  <= 1'b0;
      cnt_q    <= 5'd0;
      work_q   <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      opCode_q <= opCode_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      signA_q  <= signA_d;
      signB_q  <= signB_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
//   Scoreboard bench for muldiv_ctrl. Stimulus pushes the expected HI/LO write
//   for every op that should complete; a monitor pops and compares whenever the
//   DUT presents a non-zero write mode. Busy length, flush and reset behaviour
//   are checked directly by the stimulus.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;

  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic [1:0]  hilo_mode;
  logic [31:0] hilo_hi;
  logic [31:0] hilo_lo;

  exp_t expQ[$];
  exp_t monE;
  int   total;
  int   bad;
  int   busyCnt;

  muldiv_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op_code  (op_code),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .busy     (busy),
    .hilo_mode(hilo_mode),
    .hilo_hi  (hilo_hi),
    .hilo_lo  (hilo_lo)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point shared by stimulus and monitor.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (hilo_mode !== 2'b00) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write: actual mode=%b required none", hilo_mode);
      end else begin
        monE = expQ.pop_front();
        checkOutput("wb_mode", {30'd0, hilo_mode}, {30'd0, monE.mode});
        if (monE.mode[1]) checkOutput("wb_hi", hilo_hi, monE.hi);
        if (monE.mode[0]) checkOutput("wb_lo", hilo_lo, monE.lo);
      end
    end
  end

  // Issue one op and follow it until busy drops, checking the stall length.
  task automatic applyStimulus(input string name, input logic [2:0] code,
                               input logic [31:0] a, input logic [31:0] b,
                               input int expBusy);
    @(posedge clk); #1;
    op_valid = 1'b1;
    op_code  = code;
    src_a    = a;
    src_b    = b;
    busyCnt  = 0;
    @(negedge clk);
    if (busy) busyCnt++;
    @(posedge clk); #1;
    op_valid = 1'b0;
    op_code  = 3'd0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      busyCnt++;
    end
    checkOutput({name, "_busy_cycles"}, busyCnt, expBusy);
  endtask

  task automatic pushExp(input logic [1:0] m, input logic [31:0] h,
                         input logic [31:0] l);
    exp_t e;
    e.mode = m;
    e.hi   = h;
    e.lo   = l;
    expQ.push_back(e);
  endtask

  // Global bound so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    op_valid = 1'b0;
    op_code  = 3'd0;
    src_a    = 32'd0;
    src_b    = 32'd0;
    flush    = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_mode", {30'd0, hilo_mode}, 32'd0);
    checkOutput("reset_hi", hilo_hi, 32'd0);
    checkOutput("reset_lo", hilo_lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Multiply and divide directed vectors.
    pushExp(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFA);
    applyStimulus("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 2);
    pushExp(2'b11, 32'h00000002, 32'hFFFFFFFA);
    applyStimulus("multu", 3'd2, 32'hFFFFFFFE, 32'd3, 2);
    pushExp(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFD);
    applyStimulus("div_m7_2", 3'd3, 32'hFFFFFFF9, 32'd2, 33);
    pushExp(2'b11, 32'd2, 32'd14);
    applyStimulus("divu_100_7", 3'd4, 32'd100, 32'd7, 33);
    pushExp(2'b11, 32'h12345678, 32'hFFFFFFFF);
    applyStimulus("divu_by0", 3'd4, 32'h12345678, 32'd0, 33);
    pushExp(2'b11, 32'h00000000, 32'h80000000);
    applyStimulus("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 33);
    pushExp(2'b11, 32'd1, 32'hFFFFFFFD);
    applyStimulus("div_7_m2", 3'd3, 32'd7, 32'hFFFFFFFE, 33);
    pushExp(2'b11, 32'hFFFFFFFF, 32'd3);
    applyStimulus("div_m7_m2", 3'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 33);

    // MTHI then MTLO in consecutive cycles: never busy.
    pushExp(2'b10, 32'hAAAA5555, 32'd0);
    pushExp(2'b01, 32'd0, 32'h00001234);
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = 3'd5; src_a = 32'hAAAA5555;
    @(negedge clk);
    checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    op_code = 3'd6; src_a = 32'h00001234;
    @(negedge clk);
    checkOutput("mtlo_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0;
    @(negedge clk);
    checkOutput("mtlo_wb_busy", {31'd0, busy}, 32'd0);

    // MULT followed by MTLO accepted in the MULT's WB cycle.
    pushExp(2'b11, 32'd0, 32'h00000200);
    pushExp(2'b01, 32'd0, 32'h00000055);
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = 3'd1; src_a = 32'h10; src_b = 32'h20;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0;
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = 3'd6; src_a = 32'h55;
    @(negedge clk);
    checkOutput("b2b_wb_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0;
    @(negedge clk);

    // DIVU flushed at iteration 10: no write may ever appear for it.
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = 3'd4; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_cycle_mode", {30'd0, hilo_mode}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("after_flush_busy", {31'd0, busy}, 32'd0);
    checkOutput("after_flush_mode", {30'd0, hilo_mode}, 32'd0);
    repeat (40) @(posedge clk);

    pushExp(2'b11, 32'd0, 32'd30);
    applyStimulus("multu_5_6", 3'd2, 32'd5, 32'd6, 2);

    // MULT flushed in its WB cycle: write suppressed.
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = 3'd1; src_a = 32'd3; src_b = 32'd4;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_wb_mode", {30'd0, hilo_mode}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_wb_after_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a DIV clears busy, mode and data.
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = 3'd3; src_a = 32'd77; src_b = 32'd5;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_reset_mode", {30'd0, hilo_mode}, 32'd0);
    checkOutput("mid_reset_hi", hilo_hi, 32'd0);
    checkOutput("mid_reset_lo", hilo_lo, 32'd0);
    repeat (40) @(posedge clk);
    @(negedge clk);

    // Every expected write must have been seen.
    checkOutput("pending_writes", expQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multiply/divide sequencer for the MIPS core's HI/LO path. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and runs a 1-cycle registered multiply or a 32-iteration restoring divide. It stalls the pipeline while busy, then drives the HI/LO register write port: a 2-bit mode plus hi/lo data. It sits between the EX stage and the HI/LO register and owns every write to it.

## Interface
- No parameters (data width fixed at 32).
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `op_valid`  in  1  one-cycle pulse on the first cycle an instruction occupies EX; the pipeline never re-pulses a stalled instruction.
- `op_code`  in  3  1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO; 0/7 = no HI/LO op, ignored.
- `src_a`  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data).
- `src_b`  in  32  rt operand (divisor / multiplier).
- `flush`  in  1  exception/cancel; kills the op in flight.
- `busy`  out  1  stall request to EX.
- `hilo_mode`  out  2  HI/LO write mode: 00 none, 01 LO only, 10 HI only, 11 both.
- `hilo_hi`  out  32  HI write data (valid when mode is 10 or 11).
- `hilo_lo`  out  32  LO write data (valid when mode is 01 or 11).

## Operation
- States: IDLE, MUL, DIV, WB. Reset goes to IDLE. The internal 5-bit iteration counter and the 64-bit remainder/quotient working register clear to 0.
- Accept: an op is accepted when `op_valid` is high, `op_code` is 1–6, `flush` is low, and state is IDLE or WB.
  - Operands and op are latched at the accepting edge.
  - In MUL/DIV, `op_valid` is ignored; it cannot legally occur because `busy` is high.
- MULT/MULTU: accept → MUL → WB.
  - In MUL, the 64-bit product is registered: signed for MULT, unsigned for MULTU.
  - In WB: mode=11, hi=product[63:32], lo=product[31:0].
- DIV/DIVU:
  - At accept, latch the operand magnitudes and the signs (signs used by DIV only).
  - DIV runs 32 iterations, counter 0..31, one quotient bit per cycle, restoring algorithm.
  - Counter 31 → WB.
  - In WB, sign fix (DIV only): quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Output: mode=11, hi=remainder, lo=quotient.
- Divide by zero: the result is whatever the magnitude algorithm plus sign fix produces. For DIVU x/0: LO=FFFFFFFF, HI=x. No trap.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI/MTLO: accept → WB directly. In WB: mode=10 (hi=src_a) or 01 (lo=src_a). No stall.
- WB exit:
  - Go to MUL/DIV/WB if a new op is accepted in the same cycle.
  - Otherwise go to IDLE.
- `busy` (combinational) = (accept of MULT/MULTU/DIV/DIVU this cycle) OR state∈{MUL, DIV}. It is low in WB so the owning instruction leaves EX that cycle.
- Outputs in IDLE/MUL/DIV: mode=00. Hi/lo data hold their last value (0 after reset).
- Flush:
  - Any state → IDLE at the next edge. Counter and working register are cleared.
  - When `flush` is high, mode is forced to 00 combinationally in that cycle, including in WB, so a squashed result is never written.
  - Flush beats `op_valid`: nothing is accepted.
- Reset mid-operation: identical to flush, and the outputs also reset (mode=00, busy=0, data=0).

## Timing
- Cycle 0 is the accept cycle.
- MULT/MULTU: busy high in cycles 0–1. WB in cycle 2 (mode=11, busy=0). EX occupancy is 3 cycles.
- DIV/DIVU: busy high in cycles 0–32. DIV iterations run in cycles 1–32. WB in cycle 33. EX occupancy is 34 cycles.
- MTHI/MTLO: busy never asserted. WB (write) in cycle 1, overlapping the next instruction's EX cycle.
- Back-to-back: an op accepted in a WB cycle starts at the next edge. The earlier result is written in the current cycle, so write order equals program order.
- `hilo_mode` and the data are stable for the whole WB cycle. The HI/LO register commits them at the edge ending WB.

## Test plan
- MULT: src_a=0xFFFFFFFE (−2), src_b=3 → busy high 2 cycles, then mode=11, hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV: src_a=−7 (0xFFFFFFF9), src_b=2 → busy exactly 33 cycles, then WB with lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2.
- DIVU 0x12345678 / 0 → lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0xAAAA5555, then MTLO 0x1234 in consecutive cycles → busy never high; cycle 1 mode=10 hi=0xAAAA5555; cycle 2 mode=01 lo=0x1234.
- DIVU issued, flush at iteration 10 → IDLE next cycle, busy low, mode stays 00 for the rest of the run. A following MULTU 5×6 completes normally with lo=30, hi=0.
- MULT with flush asserted in its WB cycle → mode=00 that cycle. Separately, reset asserted mid-DIV → busy=0, mode=00, hilo_hi/lo=0 next cycle.
